load_store_unit: RTL

- Executes the data-memory access described by the decoder's memory controls (`mem_read_en`, `mem_write_en`, `mem_width`, `sign_extend`) against a word-wide data bus.
- Handles byte, half and word accesses, including misaligned ones that cross a word boundary; these are split into two bus beats.
- Sits between the execute stage, which supplies the address and store data, and the data memory or bus fabric.
- Returns one response per request: load data, or a fault.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   XLEN / NBYTES : data width and number of byte lanes (only 32 / 4 supported)
//   lsu_state_e   : sequencing states of the unit
//   mem_width_e   : access size encoding from the decoder (3 is illegal)
//   lane_mask()   : right-aligned byte-lane mask for an access size
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int NBYTES = XLEN / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_e;

  function automatic logic [NBYTES-1:0] lane_mask(input logic [1:0] width);
    case (mem_width_e'(width))
      BYTE:    lane_mask = 4'b0001;
      HALF:    lane_mask = 4'b0011;
      default: lane_mask = {NBYTES{1'b1}};
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
//   i_off, i_width      : byte offset within the word and access size
//   i_sign              : sign-extend load result (ignored for words)
//   i_wdata             : right-aligned store data
//   i_word0, i_word1    : first and second bus words of a load
//   o_cross             : access spills into the next word
//   o_strb0/1, o_wdata0/1 : per-beat lane strobes and lane-aligned store data
//   o_load              : extracted and extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        i_off,
  input  logic [1:0]        i_width,
  input  logic              i_sign,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_word0,
  input  logic [XLEN-1:0]   i_word1,
  output logic              o_cross,
  output logic [NBYTES-1:0] o_strb0,
  output logic [NBYTES-1:0] o_strb1,
  output logic [XLEN-1:0]   o_wdata0,
  output logic [XLEN-1:0]   o_wdata1,
  output logic [XLEN-1:0]   o_load
);

  logic [3:0]          w_nbytes;
  logic [3:0]          w_end;
  logic [4:0]          w_bitoff;
  logic [2*NBYTES-1:0] w_mask2;
  logic [2*XLEN-1:0]   w_wdata2;
  logic [XLEN-1:0]     w_shifted;

  assign w_nbytes = 4'd1 << i_width;
  assign w_end    = {2'b00, i_off} + w_nbytes;
  assign o_cross  = (w_end > 4'(NBYTES));
  assign w_bitoff = {i_off, 3'b000};

  // Shifting into a double-width window yields beat 0 in the low half and
  // the spill-over for beat 1 in the high half in one step.
  assign w_mask2               = {{NBYTES{1'b0}}, lane_mask(i_width)} << i_off;
  assign {o_strb1, o_strb0}    = w_mask2;
  assign w_wdata2              = {{XLEN{1'b0}}, i_wdata} << w_bitoff;
  assign {o_wdata1, o_wdata0}  = w_wdata2;

  assign w_shifted = XLEN'({i_word1, i_word0} >> w_bitoff);

  always_comb begin
    o_load = w_shifted;
    case (mem_width_e'(i_width))
      BYTE:    o_load = {{(XLEN-8){i_sign & w_shifted[7]}}, w_shifted[7:0]};
      HALF:    o_load = {{(XLEN-16){i_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory access per request over a word bus,
// splitting accesses that cross a word boundary into two beats.
//   clk, rst          : clock, synchronous active-high reset
//   req_*/mem_*/addr/wdata/sign_extend : request from execute stage
//   resp_valid/rdata/fault : one-cycle response per request
//   bus_*             : single-outstanding word bus (req/gnt, then rvalid)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            mem_read_en,
  input  logic            mem_write_en,
  input  logic [1:0]      mem_width,
  input  logic            sign_extend,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] rdata,
  output logic            fault,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  lsu_state_e      r_state, w_state_next;
  logic [1:0]      r_off, r_width;
  logic            r_sign, r_store;
  logic [XLEN-1:0] r_wdata, r_word0, w_word0_next;
  logic            r_bus_req, w_bus_req_next;
  logic            r_bus_we, w_bus_we_next;
  logic [XLEN-1:0] r_bus_addr, w_bus_addr_next;
  logic [3:0]      r_bus_wstrb, w_bus_wstrb_next;
  logic [XLEN-1:0] r_bus_wdata, w_bus_wdata_next;
  logic            r_resp_valid, w_resp_valid_next;
  logic            r_fault, w_fault_next;
  logic [XLEN-1:0] r_rdata, w_rdata_next;

  logic            w_idle, w_accept, w_req_fault, w_req_noop, w_store;
  logic [1:0]      w_off, w_width;
  logic [XLEN-1:0] w_wdata, w_align_word0;
  logic            w_cross;
  logic [3:0]      w_strb0, w_strb1;
  logic [XLEN-1:0] w_wdata0, w_wdata1, w_load;

  assign w_idle      = (r_state == IDLE);
  assign req_ready   = w_idle & ~rst;
  assign w_accept    = req_valid & req_ready;
  assign w_req_fault = (mem_width == 2'd3) | (mem_read_en & mem_write_en);
  assign w_req_noop  = ~mem_read_en & ~mem_write_en;

  // In IDLE the aligner looks at the live request so beat 0 can be
  // registered onto the bus at the accept edge; afterwards it uses the
  // latched copy.
  assign w_off   = w_idle ? addr[1:0]    : r_off;
  assign w_width = w_idle ? mem_width    : r_width;
  assign w_wdata = w_idle ? wdata        : r_wdata;
  assign w_store = w_idle ? mem_write_en : r_store;

  // A non-crossing load completes in WAIT0, so its only word is still on
  // bus_rdata rather than in r_word0.
  assign w_align_word0 = (r_state == WAIT0) ? bus_rdata : r_word0;

  lsu_align u_align (
    .i_off    (w_off),
    .i_width  (w_width),
    .i_sign   (r_sign),
    .i_wdata  (w_wdata),
    .i_word0  (w_align_word0),
    .i_word1  (bus_rdata),
    .o_cross  (w_cross),
    .o_strb0  (w_strb0),
    .o_strb1  (w_strb1),
    .o_wdata0 (w_wdata0),
    .o_wdata1 (w_wdata1),
    .o_load   (w_load)
  );

  always_comb begin
    w_state_next      = r_state;
    w_word0_next      = r_word0;
    w_bus_req_next    = 1'b0;
    w_bus_we_next     = r_bus_we;
    w_bus_addr_next   = r_bus_addr;
    w_bus_wstrb_next  = r_bus_wstrb;
    w_bus_wdata_next  = r_bus_wdata;
    w_resp_valid_next = 1'b0;
    w_fault_next      = 1'b0;
    w_rdata_next      = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_fault || w_req_noop) begin
            w_state_next      = RESP;
            w_resp_valid_next = 1'b1;
            w_fault_next      = w_req_fault;
          end else begin
            w_state_next     = REQ0;
            w_bus_req_next   = 1'b1;
            w_bus_addr_next  = {addr[XLEN-1:2], 2'b00};
            w_bus_we_next    = w_store;
            w_bus_wstrb_next = w_store ? w_strb0 : 4'b0000;
            w_bus_wdata_next = w_store ? w_wdata0 : '0;
          end
        end
      end
      REQ0: begin
        if (bus_gnt) w_state_next = WAIT0;
        else         w_bus_req_next = 1'b1;
      end
      WAIT0: begin
        if (bus_rvalid) begin
          w_word0_next = bus_rdata;
          if (w_cross) begin
            w_state_next     = REQ1;
            w_bus_req_next   = 1'b1;
            w_bus_addr_next  = r_bus_addr + XLEN'(4);
            w_bus_wstrb_next = w_store ? w_strb1 : 4'b0000;
            w_bus_wdata_next = w_store ? w_wdata1 : '0;
          end else begin
            w_state_next      = RESP;
            w_resp_valid_next = 1'b1;
            w_rdata_next      = w_store ? '0 : w_load;
          end
        end
      end
      REQ1: begin
        if (bus_gnt) w_state_next = WAIT1;
        else         w_bus_req_next = 1'b1;
      end
      WAIT1: begin
        if (bus_rvalid) begin
          w_state_next      = RESP;
          w_resp_valid_next = 1'b1;
          w_rdata_next      = w_store ? '0 : w_load;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_off        <= '0;
      r_width      <= '0;
      r_sign       <= 1'b0;
      r_store      <= 1'b0;
      r_wdata      <= '0;
      r_word0      <= '0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wstrb  <= '0;
      r_bus_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_word0      <= w_word0_next;
      r_bus_req    <= w_bus_req_next;
      r_bus_we     <= w_bus_we_next;
      r_bus_addr   <= w_bus_addr_next;
      r_bus_wstrb  <= w_bus_wstrb_next;
      r_bus_wdata  <= w_bus_wdata_next;
      r_resp_valid <= w_resp_valid_next;
      r_fault      <= w_fault_next;
      r_rdata      <= w_rdata_next;
      if (w_accept) begin
        r_off   <= addr[1:0];
        r_width <= mem_width;
        r_sign  <= sign_extend;
        r_store <= mem_write_en;
        r_wdata <= wdata;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign rdata      = r_rdata;
  assign fault      = r_fault;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wstrb  = r_bus_wstrb;
  assign bus_wdata  = r_bus_wdata;

endmodule
